// File: rtl/stage_if_pkg.sv
// -----------------------------------------------------------------------------
// stage_if_pkg
// Shared types and constants for the instruction-fetch stage.
//   - if_state_e  : fetch FSM state encoding (2 bits)
//   - fetch_pkt_t : {pc, inst} pair carried to the IF/ID register
//   - DEF_RESET_PC / DEF_NOP_INST : default parameter values
//   - word_align() : clears the two low address bits
// -----------------------------------------------------------------------------
package stage_if_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IF_S_REQ  = 2'd0,  // request outstanding on the bus (imem_req=1)
    IF_S_WAIT = 2'd1,  // granted, waiting for rvalid
    IF_S_HOLD = 2'd2,  // data parked in pending while IF/ID is stalled
    IF_S_DROP = 2'd3   // granted request became stale, swallow its rvalid
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_if_if.sv
// -----------------------------------------------------------------------------
// stage_if_if
// Instruction-memory port of the fetch stage: single-outstanding
// req/gnt/rvalid handshake.
//   imem_req    fetch request valid            (fetch -> memory)
//   imem_addr   word-aligned fetch address     (fetch -> memory)
//   imem_gnt    request accepted this cycle    (memory -> fetch)
//   imem_rvalid read data valid                (memory -> fetch)
//   imem_rdata  instruction word               (memory -> fetch)
// master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface stage_if_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_out_buf.sv
// -----------------------------------------------------------------------------
// if_out_buf
// IF/ID output register plus a one-entry pending slot.
//   clk, rst     clock, asynchronous active-high reset
//   flush_i      redirect: invalidate output (NOP) and drop pending
//   load_i       write load_pkt_i straight into the output register
//   push_i       park load_pkt_i in the pending slot (output is stalled)
//   pop_i        move the pending slot into the output register
//   stall_i      hold a valid output unchanged
//   load_pkt_i   {pc, inst} of the returning fetch
//   if_pc_o / if_inst_o / if_valid_o  presented instruction
// With no load/pop and no stall, the output drops to NOP/invalid while
// the PC is left as it was.
// -----------------------------------------------------------------------------
module if_out_buf
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        stall_i,
  input  fetch_pkt_t  load_pkt_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  fetch_pkt_t out_q, out_d;
  fetch_pkt_t pend_q, pend_d;
  logic       out_valid_q, out_valid_d;
  logic       pend_valid_q, pend_valid_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (flush_i) begin
      out_valid_d  = 1'b0;
      out_d.inst   = NOP_INST;
      pend_valid_d = 1'b0;
    end else begin
      if (load_i) begin
        out_d       = load_pkt_i;
        out_valid_d = 1'b1;
      end else if (pop_i && pend_valid_q) begin
        out_d        = pend_q;
        out_valid_d  = 1'b1;
        pend_valid_d = 1'b0;
      end else if (!(stall_i && out_valid_q)) begin
        // Output consumed (or already empty): present a bubble, keep PC.
        out_valid_d = 1'b0;
        out_d.inst  = NOP_INST;
      end

      if (push_i) begin
        pend_d       = load_pkt_i;
        pend_valid_d = 1'b1;
      end
    end
  end

  // NOTE: the pending payload is reset along with its valid bit; it is only
  // one entry wide, so a deterministic reset value costs nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '{pc: RESET_PC, inst: NOP_INST};
      out_valid_q  <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign if_pc_o    = out_q.pc;
  assign if_inst_o  = out_q.inst;
  assign if_valid_o = out_valid_q;

endmodule

// File: rtl/stage_if.sv
// -----------------------------------------------------------------------------
// stage_if
// Instruction-fetch stage. Owns the fetch PC, drives a single-outstanding
// req/gnt/rvalid instruction-memory port and presents pc/inst/valid to the
// IF/ID register. A redirect from EX (br_ctrl/br_pc) has top priority: it
// reloads the PC, flushes the output and pending slot, and discards any
// in-flight fetch.
//   clk, rst     clock, asynchronous active-high reset
//   stall_if     hold IF/ID outputs (load-use stall)
//   br_ctrl      redirect request; br_pc target (bits [1:0] ignored)
//   imem         instruction-memory port (stage_if_if.master)
//   if_pc, if_inst, if_valid   presented instruction
// -----------------------------------------------------------------------------
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_if,
  input  logic         br_ctrl,
  input  logic [31:0]  br_pc,
  stage_if_if.master   imem,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_inst,
  output logic         if_valid
);

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic        out_free;
  logic        buf_load, buf_push, buf_pop;
  fetch_pkt_t  rsp_pkt;

  assign out_free = !stall_if || !if_valid;
  assign rsp_pkt  = '{pc: req_pc_q, inst: imem.imem_rdata};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IF_S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // Next-state and PC logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;

    unique case (state_q)
      IF_S_REQ: begin
        if (imem.imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;  // wraps modulo 2^32
          // A grant in the redirect cycle fetches from the old stream.
          state_d    = br_ctrl ? IF_S_DROP : IF_S_WAIT;
        end
      end
      IF_S_WAIT: begin
        if (br_ctrl)
          state_d = imem.imem_rvalid ? IF_S_REQ : IF_S_DROP;
        else if (imem.imem_rvalid)
          state_d = out_free ? IF_S_REQ : IF_S_HOLD;
      end
      IF_S_HOLD: begin
        if (br_ctrl || !stall_if)
          state_d = IF_S_REQ;
      end
      IF_S_DROP: begin
        if (imem.imem_rvalid)
          state_d = IF_S_REQ;
      end
      default: state_d = IF_S_REQ;
    endcase

    // The redirect target beats the +4 increment in every state.
    if (br_ctrl)
      fetch_pc_d = word_align(br_pc);
  end

  // Output logic
  always_comb begin
    imem.imem_req  = (state_q == IF_S_REQ) && !rst;
    imem.imem_addr = fetch_pc_q;
    buf_load       = 1'b0;
    buf_push       = 1'b0;
    buf_pop        = 1'b0;

    unique case (state_q)
      IF_S_WAIT: begin
        if (imem.imem_rvalid && !br_ctrl) begin
          buf_load = out_free;
          buf_push = !out_free;
        end
      end
      IF_S_HOLD: buf_pop = !stall_if && !br_ctrl;
      default: ;
    endcase
  end

  if_out_buf #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (br_ctrl),
    .load_i     (buf_load),
    .push_i     (buf_push),
    .pop_i      (buf_pop),
    .stall_i    (stall_if),
    .load_pkt_i (rsp_pkt),
    .if_pc_o    (if_pc),
    .if_inst_o  (if_inst),
    .if_valid_o (if_valid)
  );

`ifndef SYNTHESIS
  // Memory must not return data when no request is in flight.
  a_rvalid_in_flight : assert property (@(posedge clk) disable iff (rst)
    !(imem.imem_rvalid && (state_q == IF_S_REQ || state_q == IF_S_HOLD)));
`endif

endmodule

// File: tb/tb_stage_if.sv
// -----------------------------------------------------------------------------
// tb_stage_if
// Directed bench for stage_if. The stimulus thread plays the instruction
// memory by hand and, whenever it returns a word that must reach IF/ID,
// pushes the expected {pc, inst} into a queue. A separate monitor pops the
// queue each time a new instruction is presented (if_valid rising into a
// fresh presentation, not a stall hold) and compares it.
// -----------------------------------------------------------------------------
module tb_stage_if;
  import stage_if_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        br_ctrl;
  logic [31:0] br_pc;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  stage_if_if imem_bus ();

  stage_if dut (
    .clk      (clk),
    .rst      (rst),
    .stall_if (stall_if),
    .br_ctrl  (br_ctrl),
    .br_pc    (br_pc),
    .imem     (imem_bus),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_valid (if_valid)
  );

  int         n_vec = 0;
  int         n_err = 0;
  fetch_pkt_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back('{pc: pc, inst: inst});
  endtask

  // Apply inputs for the coming edge, then wait to the falling edge so the
  // caller can sample the DUT mid-cycle.
  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic st, input logic br, input logic [31:0] bpc);
    imem_bus.imem_gnt    = gnt;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rd;
    stall_if             = st;
    br_ctrl              = br;
    br_pc                = bpc;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    logic pv;
    logic ps;
    fetch_pkt_t e;
    pv = 1'b0;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        ps = 1'b0;
      end else begin
        if (if_valid && !(pv && ps)) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: got pc=%h inst=%h expected none",
                     if_pc, if_inst);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", if_pc, e.pc);
            check("out_inst", if_inst, e.inst);
          end
        end
        pv = if_valid;
        ps = stall_if;
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    stall_if = 1'b0;
    br_ctrl  = 1'b0;
    br_pc    = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_inst", if_inst, 32'h0000_0013);
    check("rst_pc", if_pc, 32'h0);
    step();
    rst = 1'b0;

    // Grant delayed three cycles: address and request stay put.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      check("gntwait_req", 32'(imem_bus.imem_req), 32'd1);
      check("gntwait_addr", imem_bus.imem_addr, 32'h0);
      check("gntwait_fpc", dut.fetch_pc_q, 32'h0);
      step();
    end

    // Fetch pc 0 and 4 back-to-back, k=1.
    drive(1, 0, 32'h0, 0, 0, 32'h0);                       // A
    check("a_addr", imem_bus.imem_addr, 32'h0);
    step();
    expect_out(32'h0, 32'h0050_0093);
    drive(0, 1, 32'h0050_0093, 0, 0, 32'h0);               // B
    check("b_req", 32'(imem_bus.imem_req), 32'd0);
    check("b_fpc", dut.fetch_pc_q, 32'h4);
    step();
    drive(1, 0, 32'h0, 0, 0, 32'h0);                       // C
    check("c_valid", 32'(if_valid), 32'd1);
    check("c_req", 32'(imem_bus.imem_req), 32'd1);
    check("c_addr", imem_bus.imem_addr, 32'h4);
    step();
    expect_out(32'h4, 32'h00A0_0113);
    drive(0, 1, 32'h00A0_0113, 0, 0, 32'h0);               // D
    check("d_valid", 32'(if_valid), 32'd0);
    step();

    // Stall while pc=4 is presented; pc=8 returns during the stall.
    drive(1, 0, 32'h0, 1, 0, 32'h0);                       // E
    check("e_valid", 32'(if_valid), 32'd1);
    check("e_addr", imem_bus.imem_addr, 32'h8);
    step();
    expect_out(32'h8, 32'h0030_8193);
    drive(0, 1, 32'h0030_8193, 1, 0, 32'h0);               // F
    check("f_pc_hold", if_pc, 32'h4);
    step();
    drive(0, 0, 32'h0, 1, 0, 32'h0);                       // G
    check("g_state", 32'(dut.state_q), 32'(IF_S_HOLD));
    check("g_req", 32'(imem_bus.imem_req), 32'd0);
    check("g_pc_hold", if_pc, 32'h4);
    check("g_inst_hold", if_inst, 32'h00A0_0113);
    check("g_valid_hold", 32'(if_valid), 32'd1);
    step();
    drive(0, 0, 32'h0, 0, 0, 32'h0);                       // H
    check("h_req", 32'(imem_bus.imem_req), 32'd0);
    step();
    drive(1, 0, 32'h0, 0, 0, 32'h0);                       // I
    check("i_pc", if_pc, 32'h8);
    check("i_req", 32'(imem_bus.imem_req), 32'd1);
    check("i_addr", imem_bus.imem_addr, 32'hC);
    step();

    // Redirect while waiting for data; the stale word is dropped.
    drive(0, 0, 32'h0, 0, 1, 32'h0000_0103);               // J
    check("j_req", 32'(imem_bus.imem_req), 32'd0);
    step();
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);               // K
    check("k_state", 32'(dut.state_q), 32'(IF_S_DROP));
    check("k_valid", 32'(if_valid), 32'd0);
    check("k_req", 32'(imem_bus.imem_req), 32'd0);
    step();

    // Redirect to 8, then redirect again in the cycle 8 is granted.
    drive(0, 0, 32'h0, 0, 1, 32'h0000_0008);               // L
    check("l_addr", imem_bus.imem_addr, 32'h100);
    check("l_valid", 32'(if_valid), 32'd0);
    step();
    drive(1, 0, 32'h0, 0, 1, 32'h0000_0040);               // M
    check("m_addr", imem_bus.imem_addr, 32'h8);
    step();
    drive(0, 0, 32'h0, 0, 0, 32'h0);                       // N
    check("n_state", 32'(dut.state_q), 32'(IF_S_DROP));
    check("n_fpc", dut.fetch_pc_q, 32'h40);
    step();
    drive(0, 1, 32'hBADB_AD00, 0, 0, 32'h0);               // O
    check("o_req", 32'(imem_bus.imem_req), 32'd0);
    step();
    drive(1, 0, 32'h0, 0, 0, 32'h0);                       // P
    check("p_addr", imem_bus.imem_addr, 32'h40);
    check("p_valid", 32'(if_valid), 32'd0);
    step();

    // Redirect and stall together: redirect wins.
    expect_out(32'h40, 32'h0000_0033);
    drive(0, 1, 32'h0000_0033, 0, 0, 32'h0);               // Q
    step();
    drive(0, 0, 32'h0, 1, 1, 32'h0000_0200);               // R
    check("r_valid", 32'(if_valid), 32'd1);
    step();
    drive(1, 0, 32'h0, 0, 0, 32'h0);                       // S
    check("s_valid", 32'(if_valid), 32'd0);
    check("s_inst", if_inst, 32'h0000_0013);
    check("s_pc", if_pc, 32'h40);
    check("s_addr", imem_bus.imem_addr, 32'h200);
    step();
    expect_out(32'h200, 32'h0011_2023);
    drive(0, 1, 32'h0011_2023, 0, 0, 32'h0);               // T
    step();
    drive(1, 0, 32'h0, 1, 0, 32'h0);                       // U
    check("u_addr", imem_bus.imem_addr, 32'h204);
    step();

    // Asynchronous reset while waiting, output still valid (stalled).
    drive(0, 0, 32'h0, 1, 0, 32'h0);                       // V
    check("v_state", 32'(dut.state_q), 32'(IF_S_WAIT));
    check("v_valid", 32'(if_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(if_valid), 32'd0);
    check("arst_pc", if_pc, 32'h0);
    check("arst_inst", if_inst, 32'h0000_0013);
    check("arst_req", 32'(imem_bus.imem_req), 32'd0);
    check("arst_state", 32'(dut.state_q), 32'(IF_S_REQ));
    step();
    rst = 1'b0;

    // Redirect to the top word (low bits ignored) and wrap to 0.
    drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);               // W
    check("w_req", 32'(imem_bus.imem_req), 32'd1);
    check("w_addr", imem_bus.imem_addr, 32'h0);
    step();
    drive(1, 0, 32'h0, 0, 0, 32'h0);                       // X
    check("x_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    step();
    expect_out(32'hFFFF_FFFC, 32'h0000_006F);
    drive(0, 1, 32'h0000_006F, 0, 0, 32'h0);               // Y
    step();
    drive(0, 0, 32'h0, 0, 0, 32'h0);                       // Z
    check("z_req", 32'(imem_bus.imem_req), 32'd1);
    check("z_addr_wrap", imem_bus.imem_addr, 32'h0);
    check("z_valid", 32'(if_valid), 32'd1);
    step();

    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      step();
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
